// File: rtl/shared_mem_copy_master.sv
// Avalon-MM master that block-copies or block-fills words inside the shared on-chip memory.
// Copies run read/latency/write per word; fills issue one write per cycle.
module shared_mem_copy_master #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode_fill,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [ADDR_W-1:0]   length,
    input  logic [DATA_W-1:0]   fill_pattern,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [ADDR_W-1:0]   words_done,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W/8-1:0] byteenable,
    output logic                chipselect,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    input  logic [DATA_W-1:0]   readdata
);
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    typedef enum logic [2:0] {IDLE, RD, LAT, WR, FILL, FIN} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   src_q;
    logic [ADDR_W-1:0]   dst_q;
    logic [ADDR_W-1:0]   len_q;
    logic [ADDR_W-1:0]   off_q;
    logic                desc_q;
    logic                busy_q;
    logic                done_q;
    logic                aborted_q;
    logic [ADDR_W-1:0]   words_done_q;
    logic [ADDR_W-1:0]   address_q;
    logic [DATA_W/8-1:0] be_q;
    logic                cs_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;

    logic [ADDR_W-1:0]   off_init_d;
    logic [ADDR_W-1:0]   off_step_d;
    logic [ADDR_W-1:0]   words_done_d;
    logic                last_d;

    // Descending order when the destination lies above the source keeps overlapping copies intact.
    assign off_init_d   = (dst_addr > src_addr) ? (length - ONE) : '0;
    assign off_step_d   = desc_q ? (off_q - ONE) : (off_q + ONE);
    assign words_done_d = words_done_q + ONE;
    assign last_d       = (words_done_d == len_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            off_q        <= '0;
            desc_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            words_done_q <= '0;
            address_q    <= '0;
            be_q         <= '0;
            cs_q         <= 1'b0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        src_q        <= src_addr;
                        dst_q        <= dst_addr;
                        len_q        <= length;
                        words_done_q <= '0;
                        aborted_q    <= 1'b0;
                        busy_q       <= 1'b1;
                        if (length == '0) begin
                            state_q <= FIN;
                        end else if (mode_fill) begin
                            state_q   <= FILL;
                            desc_q    <= 1'b0;
                            off_q     <= '0;
                            address_q <= dst_addr;
                            cs_q      <= 1'b1;
                            write_q   <= 1'b1;
                            be_q      <= '1;
                            wdata_q   <= fill_pattern;
                        end else begin
                            state_q   <= RD;
                            desc_q    <= (dst_addr > src_addr);
                            off_q     <= off_init_d;
                            address_q <= src_addr + off_init_d;
                            cs_q      <= 1'b1;
                            write_q   <= 1'b0;
                            be_q      <= '1;
                        end
                    end
                end
                RD: begin
                    cs_q      <= 1'b0;
                    be_q      <= '0;
                    address_q <= '0;
                    aborted_q <= abort;
                    state_q   <= abort ? FIN : LAT;
                end
                LAT: begin
                    if (abort) begin
                        aborted_q <= 1'b1;
                        state_q   <= FIN;
                    end else begin
                        state_q   <= WR;
                        address_q <= dst_q + off_q;
                        cs_q      <= 1'b1;
                        write_q   <= 1'b1;
                        be_q      <= '1;
                        wdata_q   <= readdata;
                    end
                end
                WR: begin
                    // The write presented this cycle always lands, even when aborting.
                    words_done_q <= words_done_d;
                    write_q      <= 1'b0;
                    wdata_q      <= '0;
                    if (abort || last_d) begin
                        aborted_q <= abort;
                        state_q   <= FIN;
                        cs_q      <= 1'b0;
                        be_q      <= '0;
                        address_q <= '0;
                    end else begin
                        state_q   <= RD;
                        off_q     <= off_step_d;
                        address_q <= src_q + off_step_d;
                    end
                end
                FILL: begin
                    words_done_q <= words_done_d;
                    if (abort || last_d) begin
                        aborted_q <= abort;
                        state_q   <= FIN;
                        cs_q      <= 1'b0;
                        write_q   <= 1'b0;
                        be_q      <= '0;
                        address_q <= '0;
                        wdata_q   <= '0;
                    end else begin
                        off_q     <= off_step_d;
                        address_q <= dst_q + off_step_d;
                    end
                end
                FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign words_done = words_done_q;
    assign address    = address_q;
    assign byteenable = be_q;
    assign chipselect = cs_q;
    assign write      = write_q;
    assign writedata  = wdata_q;
endmodule
